interval_capture: RTL

//   Measures the clocks between a start strobe and the first sample of a line at 1.

---
 rtl/interval_capture.sv | 96 +++++++++
 1 files changed

// File: rtl/interval_capture.sv
// Interval capture: counts enabled clocks from a start strobe until i_line
// is first sampled high, then holds the result for a valid/ack handshake.
//
// Ports:
//   i_clk    clock, all logic on posedge
//   i_rst    synchronous active-high reset
//   i_en     clock enable for counting and line sampling
//   i_start  start strobe, honoured only in IDLE with i_en=1
//   i_line   measured line, synchronous, level-sensitive
//   i_ack    consumer acknowledge, honoured only in DONE (ignores i_en)
//   o_count  captured interval in enabled clocks
//   o_valid  o_count/o_ovf hold an unacknowledged result
//   o_ovf    line not high within MAXCOUNT enabled clocks
//   o_busy   state is not IDLE
module interval_capture #(
  parameter  int MAXCOUNT = 255,
  localparam int NBITS    = $clog2(MAXCOUNT) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_line,
  input  logic             i_ack,
  output logic [NBITS-1:0] o_count,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] MAX_C = NBITS'(MAXCOUNT);
  localparam logic [NBITS-1:0] ONE_C = NBITS'(1);

  state_t           state_q;
  logic [NBITS-1:0] cnt_q;
  logic [NBITS-1:0] count_q;
  logic             valid_q;
  logic             ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_en && i_start) begin
            state_q <= COUNT;
            cnt_q   <= ONE_C;
          end
        end
        COUNT: begin
          // Line-high wins over saturation on the MAXCOUNT-th clock.
          if (i_en) begin
            if (i_line) begin
              state_q <= DONE;
              count_q <= cnt_q;
              valid_q <= 1'b1;
              ovf_q   <= 1'b0;
            end else if (cnt_q == MAX_C) begin
              state_q <= DONE;
              count_q <= MAX_C;
              valid_q <= 1'b1;
              ovf_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ONE_C;
            end
          end
        end
        DONE: begin
          if (i_ack) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_count = count_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = (state_q != IDLE);

endmodule
